// File: rtl/inport_requester_pkg.sv
// inport_requester_pkg: flit type codes, header field layout, direction indices and FSM encodings.
package inport_requester_pkg;
  localparam logic [2:0] FT_HEADER = 3'b001;
  localparam logic [2:0] FT_BODY   = 3'b010;
  localparam logic [2:0] FT_TAIL   = 3'b100;
  localparam int LEN_LSB = 17;
  localparam int LEN_W   = 12;
  localparam int DX_LSB  = 4;
  localparam int DY_LSB  = 0;
  localparam int COORD_W = 4;
  localparam int DIR_L = 0;
  localparam int DIR_N = 1;
  localparam int DIR_E = 2;
  localparam int DIR_S = 3;
  localparam int DIR_W = 4;
  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_WAIT = 3'b010;
  localparam logic [2:0] ST_SEND = 3'b100;
endpackage

// File: rtl/inport_requester_xy_route.sv
// inport_requester_xy_route: dimension-ordered (X then Y) output port selection, one-hot.
module inport_requester_xy_route
  import inport_requester_pkg::*;
(
  input  logic [COORD_W-1:0] dst_x_i,
  input  logic [COORD_W-1:0] dst_y_i,
  input  logic [COORD_W-1:0] cur_x_i,
  input  logic [COORD_W-1:0] cur_y_i,
  output logic [4:0]         port_o
);
  always_comb begin
    port_o = '0;
    if (dst_x_i > cur_x_i) port_o[DIR_E] = 1'b1;
    else if (dst_x_i < cur_x_i) port_o[DIR_W] = 1'b1;
    else if (dst_y_i > cur_y_i) port_o[DIR_S] = 1'b1;
    else if (dst_y_i < cur_y_i) port_o[DIR_N] = 1'b1;
    else port_o[DIR_L] = 1'b1;
  end
endmodule

// File: rtl/inport_requester.sv
// inport_requester: input-port front end; decodes headers, requests the XY output and forwards flits while granted.
module inport_requester
  import inport_requester_pkg::*;
#(
  parameter int         FLIT_W = 32,
  parameter logic [3:0] CUR_X  = 4'd0,
  parameter logic [3:0] CUR_Y  = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic [4:0]        gnt,
  input  logic              out_ready,
  output logic [4:0]        req,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic [2:0]        flit_type,
  output logic [11:0]       length,
  output logic              err
);
  logic [2:0]        state_q, state_d, flit_type_q, flit_type_d, head_type;
  logic [4:0]        port_q, port_d, req_q, req_d, route;
  logic [11:0]       length_q, length_d, cnt_q, cnt_d, cnt_inc, hdr_len;
  logic [FLIT_W-1:0] flit_out_q, flit_out_d;
  logic              flit_valid_q, flit_valid_d, err_q, err_d;
  logic              granted, xfer, accept, discard, mid_hdr;

  inport_requester_xy_route u_route (
    .dst_x_i(fifo_dout[DX_LSB +: COORD_W]),
    .dst_y_i(fifo_dout[DY_LSB +: COORD_W]),
    .cur_x_i(CUR_X),
    .cur_y_i(CUR_Y),
    .port_o (route)
  );

  assign head_type  = fifo_dout[FLIT_W-1 -: 3];
  assign hdr_len    = fifo_dout[LEN_LSB +: LEN_W];
  assign granted    = |(gnt & port_q);
  assign xfer       = (state_q == ST_WAIT || state_q == ST_SEND) && granted && !fifo_empty && out_ready;
  assign accept     = state_q == ST_IDLE && !fifo_empty && head_type == FT_HEADER;
  assign discard    = state_q == ST_IDLE && !fifo_empty && head_type != FT_HEADER;
  assign fifo_rd_en = rst && (xfer || discard);
  assign cnt_inc    = cnt_q == 12'hfff ? cnt_q : cnt_q + 12'd1;
  // the packet's own header is always the first transfer, so any later header is a stray
  assign mid_hdr    = head_type == FT_HEADER && cnt_q != 12'd0;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    req_d        = req_q;
    length_d     = length_q;
    cnt_d        = cnt_q;
    err_d        = err_q | discard;
    flit_out_d   = flit_out_q;
    flit_valid_d = xfer;
    flit_type_d  = xfer ? (mid_hdr ? FT_BODY : head_type) : 3'b000;
    if (accept) begin
      state_d  = ST_WAIT;
      port_d   = route;
      req_d    = route;
      length_d = hdr_len;
      cnt_d    = '0;
      err_d    = err_q | (hdr_len < 12'd2);
    end
    if (state_q == ST_WAIT && granted) state_d = ST_SEND;
    if (xfer) begin
      flit_out_d = fifo_dout;
      cnt_d      = cnt_inc;
      err_d      = err_q | mid_hdr;
      if (head_type == FT_TAIL) begin
        state_d = ST_IDLE;
        req_d   = '0;
        err_d   = err_q | mid_hdr | (cnt_inc != length_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      port_q       <= '0;
      req_q        <= '0;
      length_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
      flit_type_q  <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      req_q        <= req_d;
      length_q     <= length_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
      flit_type_q  <= flit_type_d;
    end
  end

  assign req        = req_q;
  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign flit_type  = flit_type_q;
  assign length     = length_q;
  assign err        = err_q;
endmodule

// File: tb/tb_inport_requester.sv
// tb_inport_requester: directed checks of inport_requester at CUR=(1,1) with a bench-side FWFT FIFO.
module tb_inport_requester;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty, fifo_rd_en, out_ready, flit_valid, err;
  logic [31:0] fifo_dout, flit_out;
  logic [4:0]  gnt, req;
  logic [2:0]  flit_type;
  logic [11:0] length;
  logic [31:0] mem [0:63];
  logic [31:0] rx [0:63];
  int          rx_cyc [0:63];
  int          wr = 0, rd = 0, nrx = 0, cyc_n = 0, total = 0, bad = 0, base;

  inport_requester #(.FLIT_W(32), .CUR_X(4'd1), .CUR_Y(4'd1)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .gnt(gnt), .out_ready(out_ready), .req(req),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_type(flit_type),
    .length(length), .err(err)
  );

  always #5 clk = ~clk;

  assign fifo_empty = rd == wr;
  assign fifo_dout  = mem[rd % 64];

  always @(posedge clk) if (fifo_rd_en && rd != wr) rd <= rd + 1;

  always @(negedge clk) begin
    cyc_n++;
    if (flit_valid) begin
      rx[nrx]     = flit_out;
      rx_cyc[nrx] = cyc_n;
      nrx++;
    end
  end

  function automatic logic [31:0] hdr(input int len, input int dx, input int dy);
    return {3'b001, 12'(len), 9'd0, 4'(dx), 4'(dy)};
  endfunction

  function automatic logic [31:0] fl(input logic [2:0] t, input int n);
    return {t, 29'(n)};
  endfunction

  task automatic push(input logic [31:0] f);
    mem[wr % 64] = f;
    wr++;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    gnt = 5'b00100;
    out_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(flit_valid), 0);
    chk("rst_flit", flit_out, 0);
    chk("rst_type", 32'(flit_type), 0);
    chk("rst_len", 32'(length), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rden", 32'(fifo_rd_en), 0);
    // basic packet toward E
    rst = 1'b1;
    base = nrx;
    push(hdr(4, 3, 1)); push(fl(3'b010, 1)); push(fl(3'b010, 2)); push(fl(3'b100, 3));
    cyc();
    chk("t1_req", 32'(req), 32'b00100);
    cyc();
    chk("t1_type_hdr", 32'(flit_type), 32'b001);
    repeat (5) cyc();
    chk("t1_count", nrx - base, 4);
    chk("t1_burst", rx_cyc[base+3] - rx_cyc[base], 3);
    chk("t1_f0", rx[base], hdr(4, 3, 1));
    chk("t1_f3", rx[base+3], fl(3'b100, 3));
    chk("t1_req_off", 32'(req), 0);
    chk("t1_len", 32'(length), 4);
    chk("t1_err", 32'(err), 0);
    // same packet, grant withdrawn for 3 cycles after the 2nd flit
    base = nrx;
    push(hdr(4, 3, 1)); push(fl(3'b010, 11)); push(fl(3'b010, 12)); push(fl(3'b100, 13));
    repeat (3) cyc();
    gnt = 5'b00000;
    cyc();
    chk("t2_gap_req", 32'(req), 32'b00100);
    chk("t2_gap_valid", 32'(flit_valid), 0);
    repeat (2) cyc();
    chk("t2_gap_req2", 32'(req), 32'b00100);
    gnt = 5'b00100;
    repeat (4) cyc();
    chk("t2_count", nrx - base, 4);
    chk("t2_gap", rx_cyc[base+2] - rx_cyc[base+1], 4);
    chk("t2_f1", rx[base+1], fl(3'b010, 11));
    chk("t2_f2", rx[base+2], fl(3'b010, 12));
    chk("t2_f3", rx[base+3], fl(3'b100, 13));
    chk("t2_req_off", 32'(req), 0);
    chk("t2_err", 32'(err), 0);
    // local delivery with out_ready toggling
    gnt = 5'b00000;
    base = nrx;
    push(hdr(2, 1, 1)); push(fl(3'b100, 21));
    cyc();
    chk("t3_req", 32'(req), 32'b00001);
    gnt = 5'b00001;
    #1 chk("t3_rden1", 32'(fifo_rd_en), 1);
    cyc();
    out_ready = 1'b0;
    #1 chk("t3_rden_stall", 32'(fifo_rd_en), 0);
    cyc();
    out_ready = 1'b1;
    #1 chk("t3_rden2", 32'(fifo_rd_en), 1);
    cyc();
    chk("t3_count", nrx - base, 2);
    chk("t3_req_off", 32'(req), 0);
    chk("t3_err", 32'(err), 0);
    // stray BODY in IDLE is dropped, then a header toward W is still served
    push(fl(3'b010, 31));
    #1 chk("t4_rden", 32'(fifo_rd_en), 1);
    cyc();
    chk("t4_err", 32'(err), 1);
    chk("t4_req", 32'(req), 0);
    chk("t4_popped", 32'(fifo_empty), 1);
    base = nrx;
    gnt = 5'b10000;
    push(hdr(2, 0, 1)); push(fl(3'b100, 32));
    cyc();
    chk("t4_req_w", 32'(req), 32'b10000);
    repeat (3) cyc();
    chk("t4_count", nrx - base, 2);
    chk("t4_req_off", 32'(req), 0);
    // early tail: length 5 but only 3 flits, route S
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("t5_err_clr", 32'(err), 0);
    base = nrx;
    gnt = 5'b01000;
    push(hdr(5, 1, 2)); push(fl(3'b010, 41)); push(fl(3'b100, 42));
    cyc();
    chk("t5_req", 32'(req), 32'b01000);
    repeat (4) cyc();
    chk("t5_count", nrx - base, 3);
    chk("t5_err", 32'(err), 1);
    chk("t5_req_off", 32'(req), 0);
    // reset in the middle of a packet, route N
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    gnt = 5'b00010;
    push(hdr(5, 1, 0)); push(fl(3'b010, 51)); push(fl(3'b010, 52)); push(fl(3'b010, 53)); push(fl(3'b100, 54));
    cyc();
    chk("t6_req", 32'(req), 32'b00010);
    repeat (2) cyc();
    rst = 1'b0;
    #1 chk("t6_rden_rst", 32'(fifo_rd_en), 0);
    cyc();
    chk("t6_req0", 32'(req), 0);
    chk("t6_valid0", 32'(flit_valid), 0);
    chk("t6_err0", 32'(err), 0);
    chk("t6_len0", 32'(length), 0);
    rst = 1'b1;
    repeat (4) cyc();
    chk("t6_flushed", 32'(fifo_empty), 1);
    chk("t6_err_discard", 32'(err), 1);
    chk("t6_req_idle", 32'(req), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
